// File: rtl/hir_kernel_mem_server.sv
// Memory-side responder for one HIR kernel: serves reads from a host-loaded input buffer,
// captures kernel writes into a host-readable output buffer, and sequences kernel start/completion.
module hir_kernel_mem_server #(
    parameter int ADDR_W        = 7,
    parameter int RD_DATA_W     = 32,
    parameter int WR_DATA_W     = 64,
    parameter int EXPECT_WRITES = 100,
    parameter int TIMEOUT       = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 host_ld_en,
    input  logic [ADDR_W-1:0]    host_ld_addr,
    input  logic [RD_DATA_W-1:0] host_ld_data,
    input  logic [ADDR_W-1:0]    host_rb_addr,
    output logic [WR_DATA_W-1:0] host_rb_data,
    input  logic                 go,
    output logic                 busy,
    output logic                 done,
    output logic                 timed_out,
    output logic [ADDR_W:0]      wr_count,
    output logic                 tstart,
    input  logic [ADDR_W-1:0]    rd_addr,
    input  logic                 rd_en,
    output logic [RD_DATA_W-1:0] rd_data,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic                 wr_en,
    input  logic [WR_DATA_W-1:0] wr_data
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = ADDR_W + 1;
    localparam int CYC_W = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] EXPECT_C  = CNT_W'(EXPECT_WRITES);
    localparam logic [CNT_W-1:0] SAT_C     = CNT_W'(DEPTH);
    localparam logic [CYC_W-1:0] TIMEOUT_C = CYC_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     wr_count_q, wr_count_d;
    logic [CYC_W-1:0]     cyc_q, cyc_d;
    logic                 timed_out_q, timed_out_d;
    logic                 wr_inc;
    logic [RD_DATA_W-1:0] rd_data_q;
    logic [WR_DATA_W-1:0] rb_data_q;

    logic [RD_DATA_W-1:0] inbuf  [DEPTH];
    logic [WR_DATA_W-1:0] outbuf [DEPTH];

    always_comb begin
        state_d     = state_q;
        wr_count_d  = wr_count_q;
        cyc_d       = cyc_q;
        timed_out_d = timed_out_q;
        wr_inc      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d     = S_START;
                    wr_count_d  = '0;
                    cyc_d       = '0;
                    timed_out_d = 1'b0;
                end
            end
            S_START: state_d = S_RUN;
            S_RUN: begin
                cyc_d  = cyc_q + CYC_W'(1);
                wr_inc = wr_en && (wr_count_q != SAT_C);
                if (wr_inc) begin
                    wr_count_d = wr_count_q + CNT_W'(1);
                end
                // A completing write outranks a timeout landing on the same cycle.
                if (wr_inc && (wr_count_d == EXPECT_C)) begin
                    state_d = S_DONE;
                end else if (cyc_d == TIMEOUT_C) begin
                    state_d     = S_DONE;
                    timed_out_d = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_count_q  <= '0;
            cyc_q       <= '0;
            timed_out_q <= 1'b0;
            rd_data_q   <= '0;
            rb_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_count_q  <= wr_count_d;
            cyc_q       <= cyc_d;
            timed_out_q <= timed_out_d;
            if (rd_en) begin
                rd_data_q <= inbuf[rd_addr];
            end
            rb_data_q   <= outbuf[host_rb_addr];
        end
    end

    // NOTE: buffers carry no reset so they map onto plain RAM; a same-cycle write/readback returns the old word.
    always_ff @(posedge clk) begin
        if (host_ld_en && (state_q == S_IDLE)) begin
            inbuf[host_ld_addr] <= host_ld_data;
        end
        if (wr_en) begin
            outbuf[wr_addr] <= wr_data;
        end
    end

    assign busy         = (state_q == S_START) || (state_q == S_RUN);
    assign tstart       = (state_q == S_START) && !rst;
    assign done         = (state_q == S_DONE);
    assign timed_out    = timed_out_q;
    assign wr_count     = wr_count_q;
    assign rd_data      = rd_data_q;
    assign host_rb_data = rb_data_q;

endmodule

// File: tb/tb_hir_kernel_mem_server.sv
// Directed bench for hir_kernel_mem_server: main instance with EXPECT_WRITES=100, a second
// instance with TIMEOUT=16 for the forced-completion path.
module tb_hir_kernel_mem_server;

    localparam int AW = 7;
    localparam int RW = 32;
    localparam int WW = 64;

    logic          clk = 1'b0;
    logic          rst, host_ld_en, go, go2, rd_en, wr_en;
    logic [AW-1:0] host_ld_addr, host_rb_addr, rd_addr, wr_addr;
    logic [RW-1:0] host_ld_data, rd_data, rd_data2;
    logic [WW-1:0] wr_data, host_rb_data, host_rb_data2;
    logic          busy, done, timed_out, tstart;
    logic          busy2, done2, timed_out2, tstart2;
    logic [AW:0]   wr_count, wr_count2;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    hir_kernel_mem_server #(
        .ADDR_W(AW), .RD_DATA_W(RW), .WR_DATA_W(WW), .EXPECT_WRITES(100), .TIMEOUT(1024)
    ) dut (
        .clk(clk), .rst(rst),
        .host_ld_en(host_ld_en), .host_ld_addr(host_ld_addr), .host_ld_data(host_ld_data),
        .host_rb_addr(host_rb_addr), .host_rb_data(host_rb_data),
        .go(go), .busy(busy), .done(done), .timed_out(timed_out), .wr_count(wr_count),
        .tstart(tstart),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
        .wr_addr(wr_addr), .wr_en(wr_en), .wr_data(wr_data)
    );

    hir_kernel_mem_server #(
        .ADDR_W(AW), .RD_DATA_W(RW), .WR_DATA_W(WW), .EXPECT_WRITES(100), .TIMEOUT(16)
    ) dut_to (
        .clk(clk), .rst(rst),
        .host_ld_en(host_ld_en), .host_ld_addr(host_ld_addr), .host_ld_data(host_ld_data),
        .host_rb_addr(host_rb_addr), .host_rb_data(host_rb_data2),
        .go(go2), .busy(busy2), .done(done2), .timed_out(timed_out2), .wr_count(wr_count2),
        .tstart(tstart2),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data2),
        .wr_addr(wr_addr), .wr_en(wr_en), .wr_data(wr_data)
    );

    typedef struct {
        logic          ld_en;
        logic [AW-1:0] ld_addr;
        logic [RW-1:0] ld_data;
        logic          rd_en;
        logic [AW-1:0] rd_addr;
        logic          wr_en;
        logic [AW-1:0] wr_addr;
        logic [WW-1:0] wr_data;
        logic [AW-1:0] rb_addr;
        logic [RW-1:0] exp_rd;
        logic [WW-1:0] exp_rb;
        logic [AW:0]   exp_wrc;
    } vec_t;

    vec_t vecs [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dcnt, tcnt, run;
        bit seen;

        rst = 1'b1; host_ld_en = 1'b0; host_ld_addr = '0; host_ld_data = '0;
        host_rb_addr = '0; go = 1'b0; go2 = 1'b0; rd_en = 1'b0; rd_addr = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;

        // Reset state
        tick(); tick();
        check("rst_tstart", tstart, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_timed_out", timed_out, 0);
        check("rst_wr_count", wr_count, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_rb_data", host_rb_data, 0);
        rst = 1'b0;

        // Load input buffer, launch, kernel reads
        for (int i = 0; i < 100; i++) begin
            host_ld_en = 1'b1; host_ld_addr = AW'(i); host_ld_data = RW'(5 + i);
            tick();
        end
        host_ld_en = 1'b0;
        check("t1_idle_tstart", tstart, 0);
        go = 1'b1;
        tick();
        go = 1'b0;
        check("t1_tstart_after_go", tstart, 1);
        check("t1_busy_start", busy, 1);
        for (int i = 0; i < 100; i++) begin
            rd_en = 1'b1; rd_addr = AW'(i);
            tick();
            check($sformatf("t1_rd_%0d", i), rd_data, 64'(5 + i));
        end
        rd_en = 1'b0;
        check("t1_tstart_dropped", tstart, 0);

        // Kernel writes to completion
        dcnt = 0;
        for (int i = 0; i < 100; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = WW'((5 + i) + (100 + i));
            tick();
            if (done) dcnt++;
        end
        wr_en = 1'b0;
        check("t2_done_after_last", done, 1);
        check("t2_wr_count", wr_count, 100);
        check("t2_timed_out", timed_out, 0);
        tick();
        if (done) dcnt++;
        check("t2_done_pulses", dcnt, 1);
        check("t2_idle_busy", busy, 0);
        host_rb_addr = 7'd7;
        tick();
        check("t2_rb_7", host_rb_data, 119);
        host_rb_addr = 7'd57;
        tick();
        check("t2_rb_57", host_rb_data, 219);

        // Idle-state vectors: uncounted writes, read-before-write, read hold, top address
        vecs[0] = '{1'b0, 7'd0,   32'd0,          1'b0, 7'd0,   1'b1, 7'd3,   64'h11,                 7'd7,   32'd104,        64'd119,                8'd100};
        vecs[1] = '{1'b0, 7'd0,   32'd0,          1'b0, 7'd0,   1'b1, 7'd3,   64'hAA,                 7'd3,   32'd104,        64'h11,                 8'd100};
        vecs[2] = '{1'b0, 7'd0,   32'd0,          1'b1, 7'd10,  1'b0, 7'd0,   64'h0,                  7'd3,   32'd15,         64'hAA,                 8'd100};
        vecs[3] = '{1'b0, 7'd0,   32'd0,          1'b0, 7'd20,  1'b0, 7'd0,   64'h0,                  7'd57,  32'd15,         64'd219,                8'd100};
        vecs[4] = '{1'b1, 7'd127, 32'hBEEF_1234,  1'b0, 7'd0,   1'b1, 7'd127, 64'hFEDC_BA98_7654_3210, 7'd0,   32'd15,         64'd105,                8'd100};
        vecs[5] = '{1'b0, 7'd0,   32'd0,          1'b1, 7'd127, 1'b0, 7'd0,   64'h0,                  7'd127, 32'hBEEF_1234,  64'hFEDC_BA98_7654_3210, 8'd100};
        vecs[6] = '{1'b0, 7'd0,   32'd0,          1'b1, 7'd0,   1'b0, 7'd0,   64'h0,                  7'd99,  32'd5,          64'd303,                8'd100};
        for (int v = 0; v < 7; v++) begin
            host_ld_en = vecs[v].ld_en; host_ld_addr = vecs[v].ld_addr; host_ld_data = vecs[v].ld_data;
            rd_en = vecs[v].rd_en; rd_addr = vecs[v].rd_addr;
            wr_en = vecs[v].wr_en; wr_addr = vecs[v].wr_addr; wr_data = vecs[v].wr_data;
            host_rb_addr = vecs[v].rb_addr;
            tick();
            check($sformatf("vec%0d_rd", v), rd_data, vecs[v].exp_rd);
            check($sformatf("vec%0d_rb", v), host_rb_data, vecs[v].exp_rb);
            check($sformatf("vec%0d_wrc", v), wr_count, vecs[v].exp_wrc);
            check($sformatf("vec%0d_ctl", v), {tstart, busy, done}, 3'b000);
        end
        host_ld_en = 1'b0; rd_en = 1'b0; wr_en = 1'b0;

        // Timeout path on the short-timeout instance
        go2 = 1'b1;
        tick();
        go2 = 1'b0;
        check("t3_tstart", tstart2, 1);
        run = 0; seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            tick();
            if (done2) seen = 1'b1;
            else if (busy2 && !tstart2) run++;
        end
        check("t3_done_seen", seen, 1);
        check("t3_run_cycles", run, 16);
        check("t3_timed_out", timed_out2, 1);
        tick();
        check("t3_sticky", timed_out2, 1);
        check("t3_idle_busy", busy2, 0);
        go2 = 1'b1;
        tick();
        go2 = 1'b0;
        check("t3_cleared_on_go", timed_out2, 0);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            tick();
            if (done2) seen = 1'b1;
        end
        check("t3_second_done", seen, 1);

        // go held high, host load during run, then reset mid-run
        go = 1'b1; tcnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (tstart) tcnt++;
            if (k == 0) begin
                host_ld_en = 1'b1; host_ld_addr = 7'd0; host_ld_data = 32'hDEAD;
            end
        end
        go = 1'b0; host_ld_en = 1'b0;
        check("t4_one_tstart", tcnt, 1);
        check("t4_busy", busy, 1);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = WW'(i);
            tick();
            if (done) dcnt++;
        end
        wr_en = 1'b0;
        check("t5_wr_count_40", wr_count, 40);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_busy_after_rst", busy, 0);
        check("t5_wr_count_after_rst", wr_count, 0);
        check("t5_tstart_after_rst", tstart, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done) dcnt++;
        end
        check("t5_no_done", dcnt, 0);
        rd_en = 1'b1; rd_addr = 7'd0;
        tick();
        rd_en = 1'b0;
        check("t4_inbuf_unchanged", rd_data, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
